// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed seven-segment scanner with frame-synchronous shadow registers, blanking, LZ suppression and brightness
module ssd_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 131072,
    parameter int CNT_W      = 17
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    input  logic                    update_now,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] TOP = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W:0] SLICE = (CNT_W + 1)'(SCAN_DIV / 16);
    localparam logic [111:0] SEG_LUT = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };
    logic [CNT_W-1:0]        cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_blank;
    logic                    sh_lz;
    logic [3:0]              sh_bright;
    logic                    tick, wrap, load, dark;
    logic [3:0]              nib;
    logic [CNT_W:0]          thr;
    assign tick = cnt == TOP;
    assign wrap = tick && idx == LAST;
    assign load = wrap || update_now;
    assign nib  = sh_value[{idx, 2'b00} +: 4];
    assign thr  = ({{(CNT_W - 3){1'b0}}, sh_bright} + 1'b1) * SLICE;
    // a digit is suppressed when it and every digit above it are zero
    assign dark = sh_blank[idx]
               || (sh_lz && idx != '0 && (sh_value >> {idx, 2'b00}) == '0)
               || !({1'b0, cnt} < thr);
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            cnt         <= '0;
            idx         <= '0;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_lz       <= 1'b0;
            sh_bright   <= '0;
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            idx         <= wrap ? '0 : tick ? idx + 1'b1 : idx;
            frame_start <= wrap;
            if (load) begin
                sh_value  <= value;
                sh_dp     <= dp_mask;
                sh_blank  <= blank_mask;
                sh_lz     <= lz_en;
                sh_bright <= brightness;
            end
            an  <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg <= dark ? 7'h7F : SEG_LUT[nib * 7 +: 7];
            dp  <= dark | ~sh_dp[idx];
        end
    end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: table vectors, corner sequences and random stimulus against a slot-arithmetic reference model
module tb_ssd_scan_driver;
    localparam int N = 4, SD = 16, CW = 5, FR = N * SD;
    logic ClkPort = 0, Reset = 1, lz_en = 0, update_now = 0;
    logic [15:0] value = '0;
    logic [3:0] dp_mask = '0, blank_mask = '0, brightness = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp, frame_start;
    int errors = 0, checks = 0;
    logic [6:0] lut [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    // model: k = cycles since reset release; slot and digit follow from plain arithmetic
    int k = 0;
    logic [15:0] m_val;
    logic [3:0] m_dp, m_bl, m_br, e_an;
    logic m_lz, e_dp, e_fs;
    logic [6:0] e_seg;

    ssd_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .CNT_W(CW)) dut (
        .ClkPort(ClkPort), .Reset(Reset), .value(value), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .lz_en(lz_en), .brightness(brightness),
        .update_now(update_now), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start));

    always #5 ClkPort = ~ClkPort;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int d, c;
        logic lit, supp;
        if (Reset) begin
            {e_an, e_seg, e_dp, e_fs} = {4'hF, 7'h7F, 1'b1, 1'b0};
            {m_val, m_dp, m_bl, m_br, m_lz} = '0;
            k = 0;
            return;
        end
        d = (k / SD) % N;
        c = k % SD;
        supp = m_lz && d > 0 && (m_val >> (4 * d)) == 0;
        lit = !m_bl[d] && !supp && c < (m_br + 1) * (SD / 16);
        e_an = lit ? ~(4'b1 << d) : 4'hF;
        e_seg = lit ? lut[m_val[4*d +: 4]] : 7'h7F;
        e_dp = lit ? ~m_dp[d] : 1'b1;
        e_fs = (k % FR) == FR - 1;
        if (update_now || e_fs) {m_val, m_dp, m_bl, m_br, m_lz} = {value, dp_mask, blank_mask, brightness, lz_en};
        k++;
    endtask

    task automatic step();
        model_edge();
        @(posedge ClkPort);
        #1;
        chk("scan", {an, seg, dp, frame_start}, {e_an, e_seg, e_dp, e_fs});
        chk("anode_onehot", 32'($countones(~an) <= 1), 1);
    endtask

    // step until the displayed state (k-1) sits at a given frame position
    task automatic wait_disp(input int pos);
        int n = 0;
        do begin step(); n++; end while (((k - 1) % FR) != pos && n < 3 * FR);
        if (n >= 3 * FR) chk("wait_timeout", n, 0);
    endtask

    typedef struct {
        logic [15:0] val;
        logic [3:0] dpm, blk, br;
        logic lz;
        int d, pos;
        logic [3:0] an;
        logic [6:0] seg;
        logic dp;
    } vec_t;
    vec_t vt [22];

    initial begin
        int n;
        vt = '{
            '{16'h1A3F, 4'h0, 4'h0, 4'hF, 0, 0, 5, 4'b1110, 7'b0111000, 1},
            '{16'h1A3F, 4'h0, 4'h0, 4'hF, 0, 1, 5, 4'b1101, 7'b0000110, 1},
            '{16'h1A3F, 4'h0, 4'h0, 4'hF, 0, 2, 5, 4'b1011, 7'b0001000, 1},
            '{16'h1A3F, 4'h0, 4'h0, 4'hF, 0, 3, 15, 4'b0111, 7'b1001111, 1},
            '{16'h0040, 4'h0, 4'h0, 4'hF, 1, 3, 5, 4'b1111, 7'h7F, 1},
            '{16'h0040, 4'h0, 4'h0, 4'hF, 1, 2, 5, 4'b1111, 7'h7F, 1},
            '{16'h0040, 4'h0, 4'h0, 4'hF, 1, 1, 5, 4'b1101, 7'b1001100, 1},
            '{16'h0040, 4'h0, 4'h0, 4'hF, 1, 0, 5, 4'b1110, 7'b0000001, 1},
            '{16'h0000, 4'h0, 4'h0, 4'hF, 1, 0, 5, 4'b1110, 7'b0000001, 1},
            '{16'h0000, 4'h0, 4'h0, 4'hF, 1, 1, 5, 4'b1111, 7'h7F, 1},
            '{16'h0000, 4'h0, 4'h0, 4'hF, 0, 3, 5, 4'b0111, 7'b0000001, 1},
            '{16'h1A3F, 4'h0, 4'h0, 4'h3, 0, 1, 3, 4'b1101, 7'b0000110, 1},
            '{16'h1A3F, 4'h0, 4'h0, 4'h3, 0, 1, 4, 4'b1111, 7'h7F, 1},
            '{16'h1A3F, 4'h0, 4'h0, 4'h0, 0, 2, 0, 4'b1011, 7'b0001000, 1},
            '{16'h89BC, 4'h4, 4'h1, 4'hF, 0, 2, 5, 4'b1011, 7'b0000100, 0},
            '{16'h89BC, 4'h4, 4'h1, 4'hF, 0, 1, 5, 4'b1101, 7'b1100000, 1},
            '{16'h89BC, 4'h4, 4'h1, 4'hF, 0, 0, 5, 4'b1111, 7'h7F, 1},
            '{16'h89BC, 4'h4, 4'h1, 4'hF, 0, 3, 5, 4'b0111, 7'b0000000, 1},
            '{16'h5D6E, 4'h0, 4'h0, 4'hF, 0, 0, 5, 4'b1110, 7'b0110000, 1},
            '{16'h5D6E, 4'h0, 4'h0, 4'hF, 0, 2, 5, 4'b1011, 7'b1000010, 1},
            '{16'h7C28, 4'h0, 4'h0, 4'hF, 0, 2, 5, 4'b1011, 7'b0110001, 1},
            '{16'h7C28, 4'h0, 4'h0, 4'hF, 0, 3, 5, 4'b0111, 7'b0001111, 1}
        };
        step();
        step();
        chk("reset_state", {an, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        Reset = 0;
        foreach (vt[i]) begin
            {value, dp_mask, blank_mask, brightness, lz_en} = {vt[i].val, vt[i].dpm, vt[i].blk, vt[i].br, vt[i].lz};
            update_now = 1;
            step();
            update_now = 0;
            wait_disp(vt[i].d * SD + vt[i].pos);
            chk($sformatf("vec%0d", i), {an, seg, dp}, {vt[i].an, vt[i].seg, vt[i].dp});
        end
        {value, dp_mask, blank_mask, brightness, lz_en} = {16'h1111, 4'h0, 4'h0, 4'hF, 1'b0};
        update_now = 1;
        step();
        update_now = 0;
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 2 * FR);
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 2 * FR);
        chk("frame_period", n, FR);
        wait_disp(SD + 4);
        value = 16'h2222;
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 2 * FR);
        chk("hold_old_at_frame", seg, 7'b1001111);
        step();
        chk("new_after_frame", seg, 7'b0010010);
        wait_disp(2 * SD + 6);
        value = 16'h3333;
        update_now = 1;
        step();
        update_now = 0;
        chk("update_now_old", seg, 7'b0010010);
        step();
        chk("update_now_new", seg, 7'b0000110);
        wait_disp(2 * SD + 6);
        Reset = 1;
        step();
        chk("mid_reset", {an, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        Reset = 0;
        step();
        chk("restart_digit0", {an, seg}, {4'b1110, 7'b0000001});
        step();
        chk("restart_dark", an, 4'hF);
        for (int i = 0; i < 3000; i++) begin
            value = 16'($urandom);
            dp_mask = 4'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            brightness = 4'($urandom);
            lz_en = 1'($urandom);
            update_now = $urandom_range(0, 15) == 0;
            Reset = $urandom_range(0, 499) == 0;
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
